// File: rtl/lgn_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lgn_pkg : shared defaults, width helpers and head FSM encoding            |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package lgn_pkg;

  localparam int CATEGORIES_DEF        = 10;
  localparam int BITS_PER_CATEGORY_DEF = 512;
  localparam int CHUNK_DEF             = 64;

  // Sum must hold the full per-frame count, hence the +1.
  function automatic int sum_width(input int bits);
    return $clog2(bits + 1);
  endfunction

  function automatic int idx_width(input int cats);
    return (cats > 1) ? $clog2(cats) : 1;
  endfunction

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_SCAN  = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/lgn_class_head_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lgn_class_head_seq_if : input beat stream and result stream of the head   |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface lgn_class_head_seq_if import lgn_pkg::*; #(
  parameter int CATEGORIES = CATEGORIES_DEF,
  parameter int CHUNK      = CHUNK_DEF,
  parameter int SUM_W      = sum_width(BITS_PER_CATEGORY_DEF),
  parameter int IDX_W      = idx_width(CATEGORIES_DEF)
);

  logic                        in_valid;
  logic                        in_ready;
  logic [CATEGORIES*CHUNK-1:0] in_bits;
  logic                        in_last;

  logic                        out_valid;
  logic                        out_ready;
  logic [IDX_W-1:0]            out_index;
  logic [SUM_W-1:0]            out_value;
  logic [SUM_W-1:0]            out_margin;
  logic                        out_overflow;

  modport master (
    output in_valid, in_bits, in_last, out_ready,
    input  in_ready, out_valid, out_index, out_value, out_margin, out_overflow
  );

  modport slave (
    input  in_valid, in_bits, in_last, out_ready,
    output in_ready, out_valid, out_index, out_value, out_margin, out_overflow
  );

endinterface
`default_nettype wire

// File: rtl/popcount_chunk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | popcount_chunk : combinational count of set bits in an N-bit slice        |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module popcount_chunk #(
  parameter int N = 64,
  parameter int W = $clog2(N + 1)
) (
  input  wire logic [N-1:0] bits,
  output logic      [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(bits[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lgn_class_head_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lgn_class_head_seq : streaming per-category popcount with serial arg-max  |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module lgn_class_head_seq import lgn_pkg::*; #(
  parameter int CATEGORIES        = CATEGORIES_DEF,
  parameter int BITS_PER_CATEGORY = BITS_PER_CATEGORY_DEF,
  parameter int CHUNK             = CHUNK_DEF,
  parameter int SUM_W             = sum_width(BITS_PER_CATEGORY),
  parameter int IDX_W             = idx_width(CATEGORIES)
) (
  input wire logic             clk,
  input wire logic             rst,
  lgn_class_head_seq_if.slave  bus
);

  localparam int BEATS  = BITS_PER_CATEGORY / CHUNK;
  localparam int CNT_W  = $clog2(CHUNK + 1);
  localparam int BEAT_W = $clog2(BEATS + 1);

  state_t           state;
  logic [SUM_W-1:0] sums [CATEGORIES];
  logic [BEAT_W-1:0] beats;
  logic             overflow;

  logic [IDX_W-1:0] scan_k;
  logic             scan_done;
  logic [SUM_W-1:0] best;
  logic [SUM_W-1:0] second;
  logic [IDX_W-1:0] best_idx;

  logic             in_ready_reg;
  logic             out_valid_reg;
  logic [IDX_W-1:0] out_index_reg;
  logic [SUM_W-1:0] out_value_reg;
  logic [SUM_W-1:0] out_margin_reg;
  logic             out_overflow_reg;

  logic [CNT_W-1:0] chunk_cnt [CATEGORIES];
  logic [SUM_W-1:0] cur;
  logic             take;

  generate
    for (genvar c = 0; c < CATEGORIES; c++) begin : g_pop
      popcount_chunk #(.N(CHUNK)) u_pop (
        .bits  (bus.in_bits[c*CHUNK +: CHUNK]),
        .count (chunk_cnt[c])
      );
    end
  endgenerate

  assign take = bus.in_valid & in_ready_reg;
  assign cur  = sums[scan_k];

  assign bus.in_ready     = in_ready_reg;
  assign bus.out_valid    = out_valid_reg;
  assign bus.out_index    = out_index_reg;
  assign bus.out_value    = out_value_reg;
  assign bus.out_margin   = out_margin_reg;
  assign bus.out_overflow = out_overflow_reg;

  // Clamp instead of wrapping so an over-long frame still ranks sensibly.
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [CNT_W-1:0] b);
    logic [SUM_W:0] t;
    t = {1'b0, a} + (SUM_W+1)'(b);
    return t[SUM_W] ? '1 : t[SUM_W-1:0];
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_ACCUM;
      for (int c = 0; c < CATEGORIES; c++) sums[c] <= '0;
      beats     <= '0;
      overflow  <= 1'b0;
      scan_k    <= '0;
      scan_done <= 1'b0;
      best      <= '0;
      second    <= '0;
      best_idx  <= '0;
      in_ready_reg     <= 1'b1;
      out_valid_reg    <= 1'b0;
      out_index_reg    <= '0;
      out_value_reg    <= '0;
      out_margin_reg   <= '0;
      out_overflow_reg <= 1'b0;
    end else begin
      case (state)
        ST_ACCUM: begin
          if (take) begin
            for (int c = 0; c < CATEGORIES; c++) begin
              sums[c] <= sat_add(sums[c], chunk_cnt[c]);
            end
            if (beats == BEAT_W'(BEATS)) overflow <= 1'b1;
            else                         beats    <= beats + BEAT_W'(1);
            if (bus.in_last) begin
              state        <= ST_SCAN;
              in_ready_reg <= 1'b0;
              scan_k       <= '0;
              scan_done    <= 1'b0;
            end
          end
        end

        ST_SCAN: begin
          if (scan_done) begin
            // Extra cycle so the margin subtract sees the final best/second.
            out_index_reg    <= best_idx;
            out_value_reg    <= best;
            out_margin_reg   <= best - second;
            out_overflow_reg <= overflow;
            out_valid_reg    <= 1'b1;
            state            <= ST_OUT;
          end else begin
            // Strict compare keeps the lowest index on ties.
            if (scan_k == '0) begin
              best     <= cur;
              best_idx <= '0;
              second   <= '0;
            end else if (cur > best) begin
              second   <= best;
              best     <= cur;
              best_idx <= scan_k;
            end else if (cur > second) begin
              second   <= cur;
            end
            if (scan_k == IDX_W'(CATEGORIES - 1)) scan_done <= 1'b1;
            else                                  scan_k    <= scan_k + IDX_W'(1);
          end
        end

        ST_OUT: begin
          if (bus.out_ready) begin
            for (int c = 0; c < CATEGORIES; c++) sums[c] <= '0;
            beats         <= '0;
            overflow      <= 1'b0;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state         <= ST_ACCUM;
          end
        end

        default: begin
          state         <= ST_ACCUM;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
